// File: rtl/writeback_stage_pkg.sv
// Shared decode types and load funct3 encodings for the writeback stage and its helpers.
package writeback_stage_pkg;

  typedef struct packed {
    logic       enable;
    logic       reg_write;
    logic [4:0] rd;
    logic       mem_read;
    logic [2:0] funct3;
  } DecodeInfo;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Combinational sub-word load selection with sign or zero extension.
module load_align
  import writeback_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{addr, 3'b000} +: 8];
  assign half_sel = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (funct3)
      LB:      data = ext8(byte_sel, 1'b1);
      LBU:     data = ext8(byte_sel, 1'b0);
      LH:      data = ext16(half_sel, 1'b1);
      LHU:     data = ext16(half_sel, 1'b0);
      default: data = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Single-entry handshaked writeback buffer: waits for load data, aligns it and drives the register-file write port.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  DecodeInfo         info,
  input  logic [31:0]       result_in,
  input  logic              dmem_resp_valid,
  input  logic [31:0]       dmem_resp_data,
  output logic              w_enable,
  output logic [REG_AW-1:0] w_addr,
  output logic [31:0]       w_data,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic              load_pending,
  output logic [REG_AW-1:0] pending_rd,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {EMPTY, WAIT, READY} state_t;

  state_t      state;
  DecodeInfo   buf_info_p0;
  logic [31:0] buf_data_p0;
  logic [31:0] aligned;
  logic        accept;
  state_t      accept_state;

  assign in_ready     = (state == EMPTY) || (state == READY);
  assign accept       = in_valid && in_ready;
  assign accept_state = (info.enable && info.mem_read) ? WAIT : READY;

  // While waiting, buf_data_p0 still holds the load address
  load_align u_align (
    .funct3 (buf_info_p0.funct3),
    .addr   (buf_data_p0[1:0]),
    .word   (dmem_resp_data),
    .data   (aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      retired <= '0;
    end else begin
      case (state)
        EMPTY: if (accept) state <= accept_state;
        WAIT:  if (dmem_resp_valid) state <= READY;
        READY: begin
          state <= accept ? accept_state : EMPTY;
          if (buf_info_p0.enable) retired <= retired + CNT_W'(1);
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Data buffer is unreset; every output that exposes it is gated by state
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_info_p0 <= info;
      buf_data_p0 <= result_in;
    end else if (state == WAIT && dmem_resp_valid) begin
      buf_data_p0 <= aligned;
    end
  end

  assign w_enable     = (state == READY) && buf_info_p0.enable && buf_info_p0.reg_write &&
                        (buf_info_p0.rd != '0);
  assign w_addr       = (state == READY) ? buf_info_p0.rd : '0;
  assign w_data       = (state == READY) ? buf_data_p0 : '0;
  assign fwd_valid    = FWD_EN && w_enable;
  assign fwd_rd       = FWD_EN ? w_addr : '0;
  assign load_pending = (state == WAIT);
  assign pending_rd   = (state == WAIT) ? buf_info_p0.rd : '0;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized and directed checks of writeback_stage against a transaction-level reference model.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  DecodeInfo   info;
  logic [31:0] result_in;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;
  logic        w_enable;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic        load_pending;
  logic [4:0]  pending_rd;
  logic [63:0] retired;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_retired = 0;

  writeback_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .info(info),
    .result_in(result_in), .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
    .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .load_pending(load_pending), .pending_rd(pending_rd), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference load result from plain shift/mask arithmetic
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] word);
    int unsigned a, v;
    a = addr % 4;
    case (f3)
      3'd0, 3'd4: begin
        v = (word >> (8 * a)) & 32'hFF;
        if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (word >> (16 * (a / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic DecodeInfo mk(input bit en, input bit wr, input int rd, input bit ld,
                                   input int f3);
    DecodeInfo d;
    d.enable = en; d.reg_write = wr; d.rd = 5'(rd); d.mem_read = ld; d.funct3 = 3'(f3);
    return d;
  endfunction

  task automatic idle_inputs();
    in_valid = 0; info = '0; result_in = 0; dmem_resp_valid = 0; dmem_resp_data = 0;
  endtask

  // One isolated transaction: accept, optional load wait, write cycle, then drain to EMPTY
  task automatic run_one(input string tag, input DecodeInfo d, input logic [31:0] res,
                         input int delay, input logic [31:0] word, input bit early_resp);
    bit          is_load;
    logic [31:0] exp_data;
    is_load  = d.enable && d.mem_read;
    exp_data = is_load ? ref_load(d.funct3, res, word) : res;
    @(negedge clk);
    check_val({tag, ".in_ready"}, in_ready, 1);
    in_valid = 1; info = d; result_in = res;
    dmem_resp_valid = early_resp; dmem_resp_data = ~word;
    @(negedge clk);
    idle_inputs();
    if (is_load) begin
      for (int i = 0; i < delay; i++) begin
        check_val({tag, ".load_pending"}, load_pending, 1);
        check_val({tag, ".pending_rd"}, pending_rd, d.rd);
        check_val({tag, ".wait_w_enable"}, w_enable, 0);
        @(negedge clk);
      end
      check_val({tag, ".in_ready_wait"}, in_ready, 0);
      dmem_resp_valid = 1; dmem_resp_data = word;
      @(negedge clk);
      idle_inputs();
    end
    check_val({tag, ".w_enable"}, w_enable, d.enable && d.reg_write && d.rd != 0);
    check_val({tag, ".fwd_valid"}, fwd_valid, d.enable && d.reg_write && d.rd != 0);
    check_val({tag, ".w_addr"}, w_addr, d.rd);
    check_val({tag, ".fwd_rd"}, fwd_rd, d.rd);
    check_val({tag, ".w_data"}, w_data, exp_data);
    check_val({tag, ".retired_pre"}, retired, exp_retired);
    if (d.enable) exp_retired++;
    @(negedge clk);
    check_val({tag, ".retired"}, retired, exp_retired);
    check_val({tag, ".empty_w_enable"}, w_enable, 0);
    check_val({tag, ".empty_w_data"}, w_data, 0);
  endtask

  initial begin
    logic [31:0] vals[4];
    idle_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    check_val("reset.in_ready", in_ready, 1);
    check_val("reset.w_enable", w_enable, 0);
    check_val("reset.w_data", w_data, 0);
    check_val("reset.load_pending", load_pending, 0);
    check_val("reset.retired", retired, 0);
    rst = 0;

    run_one("alu_rd5", mk(1, 1, 5, 0, 0), 32'h1234_5678, 0, 0, 0);
    run_one("lb",  mk(1, 1, 7, 1, 0), 32'h0000_1003, 3, 32'h80FF_0000, 0);
    run_one("lbu", mk(1, 1, 7, 1, 4), 32'h0000_1003, 3, 32'h80FF_0000, 0);
    run_one("lh_hi",  mk(1, 1, 9, 1, 1), 32'h0000_2002, 1, 32'h8001_7FFF, 1);
    run_one("lhu_hi", mk(1, 1, 9, 1, 5), 32'h0000_2003, 2, 32'h8001_7FFF, 0);
    run_one("lh_lo",  mk(1, 1, 9, 1, 1), 32'h0000_2001, 0, 32'h8001_7FFF, 1);
    run_one("lw",     mk(1, 1, 3, 1, 2), 32'h0000_2001, 2, 32'hCAFE_F00D, 0);
    run_one("bubble", mk(0, 1, 6, 1, 0), 32'hDEAD_BEEF, 0, 0, 0);
    run_one("rd0",    mk(1, 1, 0, 0, 0), 32'h0BAD_0BAD, 0, 0, 0);

    // Four back-to-back ALU ops with full throughput
    @(negedge clk);
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        check_val("b2b.w_enable", w_enable, 1);
        check_val("b2b.w_addr", w_addr, 10 + i - 1);
        check_val("b2b.w_data", w_data, vals[i-1]);
      end
      if (i < 4) begin
        check_val("b2b.in_ready", in_ready, 1);
        vals[i] = $urandom;
        in_valid = 1; info = mk(1, 1, 10 + i, 0, 0); result_in = vals[i];
      end else begin
        idle_inputs();
      end
      @(negedge clk);
    end
    exp_retired += 4;
    check_val("b2b.retired", retired, exp_retired);

    // Randomized isolated transactions
    for (int n = 0; n < 60; n++) begin
      DecodeInfo d;
      d = mk($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 31),
             $urandom_range(0, 1), $urandom_range(0, 7));
      run_one("rand", d, $urandom, $urandom_range(0, 4), $urandom, $urandom_range(0, 1));
    end

    // Reset while waiting on a load, then a late response
    @(negedge clk);
    in_valid = 1; info = mk(1, 1, 12, 1, 0); result_in = 32'h100;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check_val("rstwait.load_pending", load_pending, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    dmem_resp_valid = 1; dmem_resp_data = 32'h7777_7777;
    @(negedge clk);
    idle_inputs();
    exp_retired = 0;
    check_val("rstwait.in_ready", in_ready, 1);
    check_val("rstwait.w_enable", w_enable, 0);
    check_val("rstwait.load_pending", load_pending, 0);
    check_val("rstwait.retired", retired, exp_retired);
    @(negedge clk);
    check_val("rstwait.w_enable_after", w_enable, 0);
    check_val("rstwait.retired_after", retired, exp_retired);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Buffered, handshaked successor to the combinational writeback path. Sits between the MEM stage and the register-file write port.
- Accepts one retiring instruction at a time and performs sub-word load alignment and sign/zero extension.
- Supports data memory with variable response latency by waiting for a load response.
- Exports forwarding and pending-load information to the hazard unit, and counts retired instructions.

Parameters:
- REG_AW, 5, register address width; must equal the width of DecodeInfo.rd.
- CNT_W, 64, retired-instruction counter width.
- FWD_EN, 1, when 0 the fwd_* outputs are tied to 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  MEM presents an instruction.
- in_ready  out  1  stage can accept.
- info  in  DecodeInfo  decoded control; uses fields enable, reg_write, rd, mem_read, funct3.
- result_in  in  32  ALU/CSR result, or load address for loads.
- dmem_resp_valid  in  1  load data valid this cycle.
- dmem_resp_data  in  32  aligned 32-bit word read from memory.
- w_enable  out  1  register-file write strobe.
- w_addr  out  REG_AW  write address.
- w_data  out  32  write data.
- fwd_valid  out  1  w_data is forwardable to rd.
- fwd_rd  out  REG_AW  forwarding destination.
- load_pending  out  1  a load in this stage is awaiting data.
- pending_rd  out  REG_AW  rd of the pending load.
- retired  out  CNT_W  count of retired instructions.

Behaviour:
- Single-entry buffer with FSM states EMPTY, WAIT, READY. Reset state is EMPTY.
- All outputs are 0 at reset and while EMPTY. The only exception is in_ready, which is 1 in EMPTY.
- in_ready = (state == EMPTY) || (state == READY).
  - In READY, the current entry retires and a new one is accepted in the same cycle.
- Accept occurs when in_valid && in_ready. The stage latches info and result_in.
  - Next state is WAIT if info.enable && info.mem_read; otherwise READY.
- WAIT:
  - dmem_resp_valid latches the aligned load data into the buffer; next state is READY.
  - Without dmem_resp_valid, the stage stays in WAIT.
  - load_pending = 1 and pending_rd = latched rd for as long as WAIT lasts.
- dmem_resp_valid outside WAIT is ignored. A response in the same cycle as a load is accepted is also ignored; memory returns data no earlier than the cycle after accept.
- READY lasts exactly one cycle:
  - Outputs: w_enable = enable && reg_write && (rd != 0); w_addr = rd; w_data = buffered value.
  - Next state is WAIT/READY if a new instruction is accepted that cycle, else EMPTY.
- Latency:
  - Non-load: write occurs in the cycle after accept.
  - Load: write occurs in the cycle after dmem_resp_valid.
- Load alignment uses a = latched address[1:0]:
  - LB/LBU (funct3 0/4): byte a, sign- or zero-extended.
  - LH/LHU (1/5): halfword selected by a[1], sign- or zero-extended; a[0] is ignored.
  - LW (2): full word.
  - funct3 3/6/7: treated as LW.
- Forwarding: fwd_valid = FWD_EN && w_enable; fwd_rd = w_addr.
- retired increments by 1 when a READY entry with info.enable = 1 leaves the stage. This includes rd = 0 and non-writing instructions. Bubbles (enable = 0) are not counted. The counter wraps modulo 2^CNT_W.
- Reset mid-operation (including in WAIT):
  - Buffer is discarded and state returns to EMPTY; retired is cleared.
  - A late response is ignored.

Decomposition:
- Shared package (common.sv): DecodeInfo (existing) and funct3 load-encoding constants (LB, LH, LW, LBU, LHU).
- State enum localparam stays in this module.
- One natural sub-module: load_align (combinational; inputs funct3, addr[1:0], word; output 32-bit extended data).

Test Plan:
- ALU op with rd = 5, result 0x1234_5678, accepted in cycle 1 -> cycle 2: w_enable = 1, w_addr = 5, w_data = 0x1234_5678, fwd_valid = 1; retired goes 0 -> 1.
- LB rd = 7, addr 0x...03, resp arrives 3 cycles later with word 0x80FF_0000 -> load_pending = 1 and pending_rd = 7 through the wait; then w_data = 0xFFFF_FF80. LBU with the same stimulus -> 0x0000_0080.
- LH addr[1] = 1 with word 0x8001_7FFF -> 0xFFFF_8001. LHU -> 0x0000_8001. LH addr[1] = 0 -> 0x0000_7FFF.
- Back-to-back in_valid for 4 ALU ops -> in_ready stays 1, four consecutive write cycles, retired = 4. Bubble (enable = 0) -> no write and no count.
- Write to rd = 0 -> w_enable = 0 and fwd_valid = 0, but retired increments.
- rst asserted while in WAIT, then resp_valid asserted -> state EMPTY, no write, retired = 0, in_ready = 1.
